serial_reduce_sched: RTL and testbench

SERIAL_REDUCE_SCHED -- requirements
Module: serial_reduce_sched

---
 rtl/serial_reduce_sched.sv | 169 ++++++++++++++++
 tb/tb_serial_reduce_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_reduce_sched.sv
// Round-robin scheduler sharing one serial reduction datapath (AND/OR/XOR families,
// optionally inverted) among NREQ requesters, evaluating WAY operand bits per cycle.
module serial_reduce_sched #(
   parameter  int WAY    = 3,
   parameter  int CHUNKS = 4,
   parameter  int NREQ   = 2,
   localparam int OPW    = WAY * CHUNKS,
   localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [3*NREQ-1:0]     op,
   input  logic [OPW*NREQ-1:0]   data,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  done,
   output logic [IDW-1:0]        done_id,
   output logic                  result,
   output logic                  err
);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    sel_q, sel_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [2:0]        op_q, op_d;
   logic [OPW-1:0]    data_q, data_d;
   logic              acc_q, acc_d;
   logic [CW-1:0]     idx_q, idx_d;
   logic              done_q, done_d;
   logic [IDW-1:0]    done_id_q, done_id_d;
   logic              result_q, result_d;
   logic              err_q, err_d;

   logic              found;
   logic [IDW-1:0]    win;
   logic [NREQ-1:0]   win_oh;
   logic [2:0]        win_op;
   logic [OPW-1:0]    win_data;
   logic              acc_nxt;

   // op[2:1] selects the base reduction; op[0] selects final inversion; 3 is illegal.
   function automatic logic reduce_step(input logic [1:0] base, input logic acc,
                                        input logic [WAY-1:0] chunk);
      case (base)
         2'b00:   return acc & (&chunk);
         2'b01:   return acc | (|chunk);
         default: return acc ^ (^chunk);
      endcase
   endfunction

   // Round-robin search: first requester at or after ptr_q, wrapping.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      win_oh   = '0;
      win_op   = '0;
      win_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
               found     = 1'b1;
               win       = IDW'(i);
               win_oh[i] = 1'b1;
               win_op    = op[3*i +: 3];
               win_data  = data[OPW*i +: OPW];
            end
         end
      end
   end

   assign acc_nxt = reduce_step(op_q[2:1], acc_q, data_q[WAY-1:0]);

   // NOTE: every signal gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      gnt_d     = '0;
      op_d      = op_q;
      data_d    = data_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      result_d  = result_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_q != '0) begin
               // Grant cycle: operands are already captured, decide where the job goes.
               if (op_q[2:1] == 2'b11) begin
                  state_d   = S_DONE;
                  done_d    = 1'b1;
                  done_id_d = sel_q;
                  result_d  = 1'b0;
                  err_d     = 1'b1;
               end else begin
                  state_d = S_EVAL;
               end
            end else if (found) begin
               gnt_d  = win_oh;
               sel_d  = win;
               op_d   = win_op;
               data_d = win_data;
               acc_d  = (win_op[2:1] == 2'b00);
               idx_d  = '0;
               ptr_d  = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            end
         end
         S_EVAL: begin
            acc_d  = acc_nxt;
            data_d = data_q >> WAY;
            idx_d  = idx_q + CW'(1);
            if (idx_q == CW'(CHUNKS - 1)) begin
               state_d   = S_DONE;
               done_d    = 1'b1;
               done_id_d = sel_q;
               result_d  = acc_nxt ^ op_q[0];
               err_d     = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         sel_q     <= '0;
         gnt_q     <= '0;
         op_q      <= '0;
         data_q    <= '0;
         acc_q     <= 1'b0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         result_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         gnt_q     <= gnt_d;
         op_q      <= op_d;
         data_q    <= data_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         result_q  <= result_d;
         err_q     <= err_d;
      end
   end

   assign gnt     = gnt_q;
   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign done_id = done_id_q;
   assign result  = result_q;
   assign err     = err_q;

endmodule

// File: tb/tb_serial_reduce_sched.sv
// Directed bench for serial_reduce_sched at WAY=3, CHUNKS=4, NREQ=2.
module tb_serial_reduce_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = '0;
   logic [5:0]  op = '0;
   logic [23:0] data = '0;
   logic [1:0]  gnt;
   logic        busy, done, result, err;
   logic [0:0]  done_id;

   int checks = 0;
   int failures = 0;

   serial_reduce_sched #(.WAY(3), .CHUNKS(4), .NREQ(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .data(data),
      .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
      .result(result), .err(err)
   );

   always #5 clk = ~clk;

   // Grant and done exclusive, grant one-hot, every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((gnt != 0 && done) || $countones(gnt) > 1) begin
            failures++;
            $display("FAIL gnt_done_excl: gnt=%b done=%b required one-hot gnt and not both", gnt, done);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(output int cyc, output logic [1:0] g);
      cyc = -1;
      g = '0;
      for (int n = 1; n <= 20 && cyc < 0; n++) begin
         tick();
         if (gnt != 0) begin
            cyc = n;
            g = gnt;
         end
      end
   endtask

   task automatic wait_done(output int lat, output int gseen);
      lat = -1;
      gseen = 0;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         tick();
         if (gnt != 0) gseen++;
         if (done) lat = n;
      end
   endtask

   // Runs one job for a single requester; corrupts its inputs right after grant.
   task automatic run_job(input int id, input logic [2:0] opc, input logic [11:0] d,
                          output logic [1:0] g, output int lat, output logic r,
                          output logic e, output logic [0:0] did, output logic bz);
      int c, gs;
      req[id] = 1'b1;
      op[3*id +: 3] = opc;
      data[12*id +: 12] = d;
      wait_gnt(c, g);
      req[id] = 1'b0;
      op[3*id +: 3] = 3'd7;
      data[12*id +: 12] = ~d;
      wait_done(lat, gs);
      r = result;
      e = err;
      did = done_id;
      bz = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (gnt !== 2'b00)    begin failures++; $display("FAIL rst_gnt: got %b expected 00", gnt); end
      checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)    begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if (result !== 1'b0)  begin failures++; $display("FAIL rst_result: got %b expected 0", result); end
      checks++; if (err !== 1'b0)     begin failures++; $display("FAIL rst_err: got %b expected 0", err); end
      checks++; if (done_id !== 1'b0) begin failures++; $display("FAIL rst_done_id: got %b expected 0", done_id); end
   endtask

   typedef struct {
      logic [2:0]  opc;
      logic [11:0] d;
      logic        exp;
   } vec_t;

   vec_t vecs[9] = '{
      '{3'd0, 12'hFFF, 1'b1}, '{3'd0, 12'hFF7, 1'b0}, '{3'd1, 12'hFFF, 1'b0},
      '{3'd4, 12'h001, 1'b1}, '{3'd5, 12'h003, 1'b1}, '{3'd2, 12'h800, 1'b1},
      '{3'd4, 12'h249, 1'b0}, '{3'd4, 12'h248, 1'b1}, '{3'd3, 12'h000, 1'b1}
   };

   task automatic test_reduce();
      logic [1:0] g, eg;
      int lat;
      logic r, e, bz;
      logic [0:0] did;
      for (int i = 0; i < 9; i++) begin
         eg = 2'b01 << (i % 2);
         run_job(i % 2, vecs[i].opc, vecs[i].d, g, lat, r, e, did, bz);
         checks++; if (g !== eg)             begin failures++; $display("FAIL red%0d_gnt: got %b expected %b", i, g, eg); end
         checks++; if (lat != 5)             begin failures++; $display("FAIL red%0d_latency: got %0d expected 5", i, lat); end
         checks++; if (r !== vecs[i].exp)    begin failures++; $display("FAIL red%0d_result: got %b expected %b", i, r, vecs[i].exp); end
         checks++; if (did !== 1'(i % 2))    begin failures++; $display("FAIL red%0d_done_id: got %0d expected %0d", i, did, i % 2); end
         checks++; if (e !== 1'b0)           begin failures++; $display("FAIL red%0d_err: got %b expected 0", i, e); end
         checks++; if (bz !== 1'b1)          begin failures++; $display("FAIL red%0d_busy_done: got %b expected 1", i, bz); end
         tick();
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL red%0d_after_done: done=%b busy=%b expected 0 0", i, done, busy); end
      end
   endtask

   task automatic test_illegal();
      logic [1:0] g;
      int lat;
      logic r, e, bz;
      logic [0:0] did;
      run_job(0, 3'd6, 12'hABC, g, lat, r, e, did, bz);
      checks++; if (lat != 1)    begin failures++; $display("FAIL ill6_latency: got %0d expected 1", lat); end
      checks++; if (e !== 1'b1)  begin failures++; $display("FAIL ill6_err: got %b expected 1", e); end
      checks++; if (r !== 1'b0)  begin failures++; $display("FAIL ill6_result: got %b expected 0", r); end
      tick();
      run_job(1, 3'd4, 12'h001, g, lat, r, e, did, bz);
      checks++; if (e !== 1'b0 || r !== 1'b1) begin failures++; $display("FAIL ill_clear: err=%b result=%b expected 0 1", e, r); end
      tick();
      run_job(1, 3'd7, 12'hFFF, g, lat, r, e, did, bz);
      checks++; if (lat != 1 || e !== 1'b1 || r !== 1'b0 || did !== 1'b1) begin
         failures++; $display("FAIL ill7: lat=%0d err=%b result=%b id=%0d expected 1 1 0 1", lat, e, r, did);
      end
      tick();
   endtask

   task automatic test_arbitration();
      logic [1:0] g, eg;
      int c, lat, gs;
      rst_n = 1'b0;
      op = {3'd2, 3'd0};
      data = {12'h000, 12'hFFF};
      req = 2'b11;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin
         eg = (n % 2 == 0) ? 2'b01 : 2'b10;
         wait_gnt(c, g);
         checks++; if (g !== eg) begin failures++; $display("FAIL arb%0d_gnt: got %b expected %b", n, g, eg); end
         if (n > 0) begin
            checks++; if (c != 2) begin failures++; $display("FAIL arb%0d_gap: got %0d expected 2", n, c); end
         end
         wait_done(lat, gs);
         checks++; if (lat != 5 || gs != 0) begin failures++; $display("FAIL arb%0d_job: latency=%0d grants_while_busy=%0d expected 5 0", n, lat, gs); end
         checks++; if (done_id !== 1'(n % 2)) begin failures++; $display("FAIL arb%0d_done_id: got %0d expected %0d", n, done_id, n % 2); end
         checks++; if (result !== ((n % 2 == 0) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL arb%0d_result: got %b expected %b", n, result, n % 2 == 0); end
      end
      req = 2'b00;
      tick(); tick();
   endtask

   task automatic test_abort();
      logic [1:0] g;
      int c, lat;
      logic r, e, bz;
      logic [0:0] did;
      run_job(1, 3'd4, 12'h001, g, lat, r, e, did, bz);
      tick();
      req = 2'b10;
      op[5:3] = 3'd0;
      data[23:12] = 12'hFFF;
      wait_gnt(c, g);
      req = 2'b00;
      tick(); tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy: got %b expected 1", busy); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if ({gnt, busy, done, done_id, result, err} !== 7'b0) begin
         failures++; $display("FAIL async_rst: gnt=%b busy=%b done=%b id=%b result=%b err=%b expected all 0", gnt, busy, done, done_id, result, err);
      end
      c = 0;
      for (int n = 0; n < 3; n++) begin tick(); if (done) c++; end
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) begin tick(); if (done) c++; end
      checks++; if (c != 0) begin failures++; $display("FAIL abort_no_done: got %0d done pulses expected 0", c); end
      run_job(1, 3'd2, 12'h800, g, lat, r, e, did, bz);
      checks++; if (g !== 2'b10 || lat != 5) begin failures++; $display("FAIL abort_rerun: gnt=%b latency=%0d expected 10 5", g, lat); end
      checks++; if (r !== 1'b1 || did !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL abort_rerun_out: result=%b id=%0d err=%b expected 1 1 0", r, did, e); end
      tick();
   endtask

   initial begin
      test_reset();
      test_reduce();
      test_illegal();
      test_arbitration();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
